multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control finite-state machine for the 16-bit multicycle RISC datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps. Every cycle it drives the select (`addr`) inputs of the datapath's 16-bit 2:1 and 4:1 operand/address muxes plus all register and memory write enables. It sits directly upstream of those muxes. It consumes the instruction-register opcode, the ALU zero flag and the memory ready handshake.

## Interface
Parameters:
- `OP_W`, default 4: opcode width, taken from IR[15:12].

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  4  IR[15:12] of the latched instruction.
- `zero`  in  1  ALU zero flag, valid in the BRANCH state.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_we`  out  1  PC load enable.
- `ir_we`  out  1  instruction-register load enable.
- `mem_re`  out  1  memory read request.
- `mem_we`  out  1  memory write request.
- `reg_we`  out  1  register-file write enable.
- `iord_sel`  out  1  address mux select: 0 = PC, 1 = ALUOut.
- `alusrca_sel`  out  1  ALU A mux select: 0 = PC, 1 = regA.
- `alusrcb_sel`  out  2  ALU B mux select: 0 = regB, 1 = constant 1, 2 = sign-extended imm, 3 = imm.
- `memtoreg_sel`  out  1  writeback mux select: 0 = ALUOut, 1 = MDR.
- `regdst_sel`  out  1  destination mux select: 0 = IR[7:4], 1 = IR[11:8].
- `pcsrc_sel`  out  2  PC source select: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `alu_op`  out  2  ALU operation: 0 = add, 1 = sub, 2 = funct-decoded.
- `state`  out  4  current state, for debug.
- `halted`  out  1  asserted in the HALT state.
- `illegal`  out  1  sticky illegal-opcode flag (see Configuration).

## Operation
- Opcodes:
  - 0 R-type
  - 1 ADDI
  - 2 LW
  - 3 SW
  - 4 BEQ
  - 5 JMP
  - F HALT
  - all others illegal
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, HALT=11.
- Outputs are a Moore decode of `state`. The exceptions are `pc_we` and `ir_we` in FETCH and the BRANCH `pc_we`, which are gated as described below.
- Any output not listed for a state is 0.
- FETCH:
  - Drives mem_re=1, iord_sel=0, alusrca_sel=0, alusrcb_sel=1, alu_op=add, pcsrc_sel=0.
  - ir_we and pc_we equal mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE:
  - Drives alusrca_sel=0, alusrcb_sel=2, alu_op=add (branch-target precompute).
  - Next state by opcode: LW/SW → MEMADR; R-type → EXEC; ADDI → ADDIEX; BEQ → BRANCH; JMP → JUMP; HALT → HALT.
  - Illegal opcodes: see Configuration.
- MEMADR: alusrca_sel=1, alusrcb_sel=2, alu_op=add. Next is MEMRD for LW, MEMWR for SW.
- MEMRD: mem_re=1, iord_sel=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_we=1, memtoreg_sel=1, regdst_sel=0, then FETCH.
- MEMWR: mem_we=1, iord_sel=1. Holds until mem_ready=1, then goes to FETCH.
- EXEC: alusrca_sel=1, alusrcb_sel=0, alu_op=funct, then ALUWB.
- ALUWB: reg_we=1, memtoreg_sel=0, regdst_sel=1, then FETCH.
- ADDIEX: alusrca_sel=1, alusrcb_sel=2, alu_op=add, then ALUWB.
- BRANCH: alusrca_sel=1, alusrcb_sel=0, alu_op=sub, pcsrc_sel=1, pc_we=zero, then FETCH.
- JUMP: pcsrc_sel=2, pc_we=1, then FETCH.
- HALT: halted=1 and all enables 0. It leaves HALT only on rst.

## Timing
- Reset:
  - rst=1 at a clock edge sets state to FETCH and clears illegal.
  - While rst=1, all enables (pc_we, ir_we, mem_re, mem_we, reg_we) are forced to 0 combinationally, all selects are 0, and halted=0.
  - Reset mid-instruction abandons it with no write performed in the reset cycle.
- Latency with zero-wait memory:
  - R-type 4 cycles; ADDI 4; LW 5; SW 4; BEQ 3; JMP 3.
  - Each memory wait cycle adds 1.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR, and ignored in other states.
- mem_re and mem_we are held high and stable until the completing cycle.
- zero is sampled only in BRANCH.
- pc_we, mem_we and reg_we are never asserted in the same cycle.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE goes to HALT and sets illegal=1.
  - illegal stays set until rst.
- `CTRL_ILLEGAL_TRAP_EN` not defined:
  - An illegal opcode in DECODE returns to FETCH and acts as a 2-cycle NOP.
  - illegal is tied to 0.

## Test plan
- Reset: assert rst for 2 cycles in the middle of an LW in MEMRD → state=0, mem_re=0 during reset, mem_re=1 in the first cycle after release.
- R-type, opcode=0, mem_ready=1 → state sequence 0,1,6,7,0; reg_we=1 only in state 7 with regdst_sel=1.
- LW with mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles, mem_re steady 1, then MEMWB with reg_we=1 and memtoreg_sel=1; total 8 cycles.
- BEQ: once with zero=1 and once with zero=0 → pc_we=1 in BRANCH with pcsrc_sel=1 only when zero=1; 3 cycles either way.
- JMP followed by HALT (opcode F) → JUMP asserts pc_we=1 with pcsrc_sel=2; HALT holds halted=1 for 10+ cycles with all enables 0, and rst recovers to FETCH.
- Opcode 7 (illegal) → with `CTRL_ILLEGAL_TRAP_EN`: HALT with illegal=1; without it: state 0,1,0 with no enable other than the fetch enables asserted.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_ctrl_if #(
    parameter int OP_W = 4
);
    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            mem_ready;
    logic            pc_we;
    logic            ir_we;
    logic            mem_re;
    logic            mem_we;
    logic            reg_we;
    logic            iord_sel;
    logic            alusrca_sel;
    logic [1:0]      alusrcb_sel;
    logic            memtoreg_sel;
    logic            regdst_sel;
    logic [1:0]      pcsrc_sel;
    logic [1:0]      alu_op;
    logic [3:0]      state;
    logic            halted;
    logic            illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_we, ir_we, mem_re, mem_we, reg_we, iord_sel, alusrca_sel,
               alusrcb_sel, memtoreg_sel, regdst_sel, pcsrc_sel, alu_op,
               state, halted, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_we, ir_we, mem_re, mem_we, reg_we, iord_sel, alusrca_sel,
               alusrcb_sel, memtoreg_sel, regdst_sel, pcsrc_sel, alu_op,
               state, halted, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 16-bit multicycle RISC datapath (Moore decode, gated fetch/branch writes).
// Optional: define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with a sticky flag.
module multicycle_ctrl #(
    parameter int OP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_HALT   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(4'hF);

    state_t     r_state, w_next;
    logic       w_pc_we, w_ir_we, w_mem_re, w_mem_we, w_reg_we;
    logic       w_iord, w_alusrca, w_memtoreg, w_regdst, w_halted;
    logic [1:0] w_alusrcb, w_pcsrc, w_alu_op;
    logic       w_illegal;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic w_trap;
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (rst)         r_illegal <= 1'b0;
        else if (w_trap) r_illegal <= 1'b1;
    end
    assign w_illegal = r_illegal;
`else
    assign w_illegal = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_pc_we    = 1'b0;
        w_ir_we    = 1'b0;
        w_mem_re   = 1'b0;
        w_mem_we   = 1'b0;
        w_reg_we   = 1'b0;
        w_iord     = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'd0;
        w_memtoreg = 1'b0;
        w_regdst   = 1'b0;
        w_pcsrc    = 2'd0;
        w_alu_op   = 2'd0;
        w_halted   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        w_trap     = 1'b0;
`endif
        unique case (r_state)
            S_FETCH: begin
                w_mem_re  = 1'b1;
                w_alusrcb = 2'd1;
                w_ir_we   = bus.mem_ready;
                w_pc_we   = bus.mem_ready;
                if (bus.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alusrcb = 2'd2;
                case (bus.opcode)
                    OP_RTYPE:      w_next = S_EXEC;
                    OP_ADDI:       w_next = S_ADDIEX;
                    OP_LW, OP_SW:  w_next = S_MEMADR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_JMP:        w_next = S_JUMP;
                    OP_HALT:       w_next = S_HALT;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        w_next = S_HALT;
                        w_trap = 1'b1;
`else
                        w_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'd2;
                w_next    = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_re = 1'b1;
                w_iord   = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_we   = 1'b1;
                w_memtoreg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_we = 1'b1;
                w_iord   = 1'b1;
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_EXEC: begin
                w_alusrca = 1'b1;
                w_alu_op  = 2'd2;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_we = 1'b1;
                w_regdst = 1'b1;
                w_next   = S_FETCH;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'd2;
                w_next    = S_ALUWB;
            end
            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_alu_op  = 2'd1;
                w_pcsrc   = 2'd1;
                w_pc_we   = bus.zero;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                w_pcsrc = 2'd2;
                w_pc_we = 1'b1;
                w_next  = S_FETCH;
            end
            S_HALT: w_halted = 1'b1;
            default: w_next = S_FETCH;
        endcase

        // Reset abandons the current instruction: nothing may be written in the reset cycle.
        if (rst) begin
            w_pc_we    = 1'b0;
            w_ir_we    = 1'b0;
            w_mem_re   = 1'b0;
            w_mem_we   = 1'b0;
            w_reg_we   = 1'b0;
            w_iord     = 1'b0;
            w_alusrca  = 1'b0;
            w_alusrcb  = 2'd0;
            w_memtoreg = 1'b0;
            w_regdst   = 1'b0;
            w_pcsrc    = 2'd0;
            w_alu_op   = 2'd0;
            w_halted   = 1'b0;
        end
    end

    assign bus.pc_we        = w_pc_we;
    assign bus.ir_we        = w_ir_we;
    assign bus.mem_re       = w_mem_re;
    assign bus.mem_we       = w_mem_we;
    assign bus.reg_we       = w_reg_we;
    assign bus.iord_sel     = w_iord;
    assign bus.alusrca_sel  = w_alusrca;
    assign bus.alusrcb_sel  = w_alusrcb;
    assign bus.memtoreg_sel = w_memtoreg;
    assign bus.regdst_sel   = w_regdst;
    assign bus.pcsrc_sel    = w_pcsrc;
    assign bus.alu_op       = w_alu_op;
    assign bus.state        = r_state;
    assign bus.halted       = w_halted;
    assign bus.illegal      = w_illegal;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from the instruction rules.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.OP_W(4)) bus ();
    multicycle_ctrl #(.OP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef logic [20:0] vec_t;
    typedef struct {
        bit   mr;
        bit   z;
        vec_t e;
    } cyc_t;

    localparam vec_t FORCED_MASK = 21'h1FFFE;

    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   exp_ill = 1'b0;
    bit   trap_mode;

    initial begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap_mode = 1'b1;
`else
        trap_mode = 1'b0;
`endif
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation did not finish");
    end

    // Fields: state, {pc_we,ir_we,mem_re,mem_we,reg_we}, iord, alusrca, alusrcb, memtoreg, regdst, pcsrc, alu_op, halted
    function automatic vec_t mk(logic [3:0] st, logic [4:0] en, bit iord, bit a, logic [1:0] b,
                                bit m2r, bit rd, logic [1:0] pcs, logic [1:0] aop, bit h);
        return {st, en, iord, a, b, m2r, rd, pcs, aop, h, exp_ill};
    endfunction

    function automatic vec_t obs();
        return {bus.state, bus.pc_we, bus.ir_we, bus.mem_re, bus.mem_we, bus.reg_we,
                bus.iord_sel, bus.alusrca_sel, bus.alusrcb_sel, bus.memtoreg_sel,
                bus.regdst_sel, bus.pcsrc_sel, bus.alu_op, bus.halted, bus.illegal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input bit mr, input bit z, input vec_t e);
        cyc_t c;
        c.mr = mr;
        c.z  = z;
        c.e  = e;
        q.push_back(c);
    endtask

    // Expected cycle-by-cycle trace of one instruction, fw fetch waits and mw memory waits.
    task automatic build(input logic [3:0] op, input bit zf, input int fw, input int mw);
        bus.opcode = op;
        for (int i = 0; i < fw; i++) add(1'b0, rb(), mk(0, 5'b00100, 0, 0, 1, 0, 0, 0, 0, 0));
        add(1'b1, rb(), mk(0, 5'b11100, 0, 0, 1, 0, 0, 0, 0, 0));
        add(rb(), rb(), mk(1, 5'b00000, 0, 0, 2, 0, 0, 0, 0, 0));
        case (op)
            4'h0: begin
                add(rb(), rb(), mk(6, 5'b00000, 0, 1, 0, 0, 0, 0, 2, 0));
                add(rb(), rb(), mk(7, 5'b00001, 0, 0, 0, 0, 1, 0, 0, 0));
            end
            4'h1: begin
                add(rb(), rb(), mk(10, 5'b00000, 0, 1, 2, 0, 0, 0, 0, 0));
                add(rb(), rb(), mk(7, 5'b00001, 0, 0, 0, 0, 1, 0, 0, 0));
            end
            4'h2: begin
                add(rb(), rb(), mk(2, 5'b00000, 0, 1, 2, 0, 0, 0, 0, 0));
                for (int i = 0; i < mw; i++) add(1'b0, rb(), mk(3, 5'b00100, 1, 0, 0, 0, 0, 0, 0, 0));
                add(1'b1, rb(), mk(3, 5'b00100, 1, 0, 0, 0, 0, 0, 0, 0));
                add(rb(), rb(), mk(4, 5'b00001, 0, 0, 0, 1, 0, 0, 0, 0));
            end
            4'h3: begin
                add(rb(), rb(), mk(2, 5'b00000, 0, 1, 2, 0, 0, 0, 0, 0));
                for (int i = 0; i < mw; i++) add(1'b0, rb(), mk(5, 5'b00010, 1, 0, 0, 0, 0, 0, 0, 0));
                add(1'b1, rb(), mk(5, 5'b00010, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            4'h4: add(rb(), zf, mk(8, {zf, 4'b0000}, 0, 1, 0, 0, 0, 1, 1, 0));
            4'h5: add(rb(), rb(), mk(9, 5'b10000, 0, 0, 0, 0, 0, 2, 0, 0));
            4'hF: add(rb(), rb(), mk(11, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1));
            default: begin
                if (trap_mode) begin
                    exp_ill = 1'b1;
                    add(rb(), rb(), mk(11, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1));
                end
            end
        endcase
    endtask

    // Drive each queued cycle just after a rising edge, then check outputs before the next edge.
    task automatic run_q(input int limit, input string tag);
        int n = 0;
        cyc_t c;
        while (q.size() > 0 && n < limit) begin
            c = q.pop_front();
            bus.mem_ready = c.mr;
            bus.zero      = c.z;
            #1;
            chk($sformatf("%s_cyc%0d", tag, n), 32'(obs()), 32'(c.e));
            chk($sformatf("%s_excl%0d", tag, n),
                32'($countones({bus.pc_we, bus.mem_we, bus.reg_we}) <= 1), 32'd1);
            @(posedge clk);
            #1;
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b1;
            bus.mem_ready = rb();
            bus.zero = rb();
            #1;
            chk($sformatf("rst_forced%0d", i), 32'(obs() & FORCED_MASK), 32'd0);
            if (i > 0) begin
                chk($sformatf("rst_state%0d", i), 32'(bus.state), 32'd0);
                chk($sformatf("rst_illegal%0d", i), 32'(bus.illegal), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_ill = 1'b0;
    endtask

    initial begin
        logic [3:0] op;
        rst = 1'b1;
        bus.opcode = 4'h0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        build(4'h0, 1'b0, 0, 0);  run_q(100, "rtype");

        // Reset in the middle of an LW that is waiting in MEMRD.
        build(4'h2, 1'b0, 0, 10); run_q(5, "lw_abort");
        do_reset(2);

        build(4'h2, 1'b0, 0, 3);  run_q(100, "lw_wait");
        build(4'h4, 1'b1, 0, 0);  run_q(100, "beq_taken");
        build(4'h4, 1'b0, 0, 0);  run_q(100, "beq_not");
        build(4'h3, 1'b0, 2, 1);  run_q(100, "sw");
        build(4'h1, 1'b0, 1, 0);  run_q(100, "addi");
        build(4'h5, 1'b0, 0, 0);  run_q(100, "jmp");

        build(4'hF, 1'b0, 0, 0);
        for (int i = 0; i < 11; i++) add(rb(), rb(), mk(11, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1));
        run_q(100, "halt");
        do_reset(2);

        build(4'h7, 1'b0, 0, 0);
        if (trap_mode) for (int i = 0; i < 3; i++) add(rb(), rb(), mk(11, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1));
        else add(1'b0, rb(), mk(0, 5'b00100, 0, 0, 1, 0, 0, 0, 0, 0));
        run_q(100, "illegal7");
        if (trap_mode) do_reset(2);

        for (int k = 0; k < 80; k++) begin
            op = 4'($urandom_range(0, 15));
            build(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
            run_q(100, $sformatf("rnd%0d_op%0h", k, op));
            if (op == 4'hF || (trap_mode && op > 4'h5)) do_reset($urandom_range(1, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
